// File: rtl/spi_reg_frame_parser.sv
// SPI register frame parser: turns each cs_n frame from the SPI slave driver into a
// command byte followed by a burst write or burst read over a small register bank.
module spi_reg_frame_parser #(
  parameter int          NUM_REGS  = 16,
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic [7:0]            rec_data,
  input  logic                  rec_valid,
  output logic [7:0]            response_data,
  output logic [8*NUM_REGS-1:0] reg_q,
  output logic                  wr_stb,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data
);

  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t                      state_reg;
  logic [6:0]                  addr_reg;
  logic                        cs_meta_reg;
  logic                        cs_s_reg;
  logic [1:0]                  fill_reg;
  logic                        armed_reg;
  logic [NUM_REGS-1:0][7:0]    bank;
  logic [6:0]                  addr_inc;
  logic                        bank_we;
  logic [7:0]                  rd_cmd_data;
  logic [7:0]                  rd_next_data;
  logic [7:0]                  wr_echo_data;

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NUM_REGS_B;
  endfunction

  // armed_reg stays low after reset until cs_s has genuinely sampled a high pad
  // level, so a frame cut by reset is ignored until the next cs_n falling edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_meta_reg <= 1'b1;
      cs_s_reg    <= 1'b1;
      fill_reg    <= 2'b00;
      armed_reg   <= 1'b0;
    end else begin
      cs_meta_reg <= cs_n;
      cs_s_reg    <= cs_meta_reg;
      fill_reg    <= {fill_reg[0], 1'b1};
      if (fill_reg[1] && cs_s_reg)
        armed_reg <= 1'b1;
    end
  end

  assign addr_inc = addr_reg + 7'd1;
  assign bank_we  = (state_reg == WRITE) && !cs_s_reg && rec_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [7:0] q_reg;
      always_ff @(posedge clk) begin
        if (!rst)
          q_reg <= RESET_VAL;
        else if (bank_we && addr_reg == 7'(gi))
          q_reg <= rec_data;
      end
      assign bank[gi] = q_reg;
    end
  endgenerate

  assign reg_q = bank;

  always_comb begin
    rd_cmd_data  = 8'h00;
    rd_next_data = 8'h00;
    wr_echo_data = 8'h00;
    if (in_range(rec_data[6:0]))
      rd_cmd_data = bank[rec_data[AW-1:0]];
    if (in_range(addr_inc))
      rd_next_data = bank[addr_inc[AW-1:0]];
    // In WRITE the master sees the post-write contents of the addressed register.
    if (in_range(addr_reg))
      wr_echo_data = rec_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      addr_reg      <= 7'd0;
      response_data <= HEADER;
      wr_stb        <= 1'b0;
      wr_addr       <= 7'd0;
      wr_data       <= 8'h00;
    end else begin
      wr_stb <= 1'b0;
      if (cs_s_reg) begin
        state_reg     <= IDLE;
        response_data <= HEADER;
      end else begin
        case (state_reg)
          IDLE: begin
            response_data <= HEADER;
            if (armed_reg)
              state_reg <= CMD;
          end
          CMD: begin
            if (rec_valid) begin
              addr_reg      <= rec_data[6:0];
              response_data <= rd_cmd_data;
              state_reg     <= rec_data[7] ? READ : WRITE;
            end
          end
          WRITE: begin
            if (rec_valid) begin
              addr_reg      <= addr_inc;
              response_data <= wr_echo_data;
              if (in_range(addr_reg)) begin
                wr_stb  <= 1'b1;
                wr_addr <= addr_reg;
                wr_data <= rec_data;
              end
            end
          end
          READ: begin
            if (rec_valid) begin
              addr_reg      <= addr_inc;
              response_data <= rd_next_data;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
